mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Memory-access stage directly downstream of the EXU address generator.
- Takes the computed effective address plus load/store info and issues one aligned 64-bit request to the data memory over a valid/ready handshake.
- For loads, waits for the response, then extracts, sign- or zero-extends and delivers data to writeback. For stores, builds the shifted write data and byte mask.
- One access in flight at a time. Misaligned accesses are trapped without touching memory.

Parameters:
- XLEN, 64, data and address width.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  upstream access valid
- in_ready  out  1  stage can accept an access
- in_addr  in  XLEN  effective address (src1+imm from EXU)
- in_wdata  in  XLEN  store data, low-aligned
- in_is_store  in  1  1 = store, 0 = load
- in_size  in  2  0=B, 1=H, 2=W, 3=D
- in_unsigned  in  1  load zero-extend
- in_rd  in  RD_W  destination register
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  {addr[63:3],3'b0}
- mem_req_wen  out  1  write enable
- mem_req_wdata  out  XLEN  shifted store data
- mem_req_wmask  out  8  byte strobes
- mem_resp_valid  in  1  read data / write ack valid
- mem_resp_rdata  in  XLEN  aligned 64-bit read data
- out_valid  out  1  result valid
- out_ready  in  1  writeback accepts result
- out_rdata  out  XLEN  extended load data (0 for stores and errors)
- out_rd  out  RD_W  latched destination register
- out_is_store  out  1  latched store flag
- out_misalign  out  1  misaligned access flag

Behaviour:
- Reset: all outputs low/zero.
  - State returns to IDLE; all latched fields cleared.
  - Reset mid-operation abandons the access and deasserts mem_req_valid in the next cycle.
  - A response arriving after reset is ignored.
- FSM IDLE, REQ, WAIT, DONE:
  - IDLE: in_ready=1 (only in IDLE). On in_valid, latch addr, wdata, is_store, size, unsigned and rd. Next state is DONE with out_misalign=1 if misaligned, otherwise REQ.
  - REQ: mem_req_valid=1, with all mem_req_* fields stable until mem_req_ready. On mem_req_ready, go to WAIT.
  - WAIT: on mem_resp_valid, register the extracted load data (0 for stores) and go to DONE. Stores also wait for the ack.
  - DONE: out_valid=1 and outputs held stable. On out_ready, return to IDLE. No same-cycle re-accept.
- mem_resp_valid outside WAIT is ignored.
- Misalignment rules: H requires addr[0]=0; W requires addr[1:0]=0; D requires addr[2:0]=0.
  - On misalignment, no memory request is issued, out_rdata=0 and out_misalign=1.
- Store data and mask:
  - sh = addr[2:0].
  - wdata = in_wdata << (8*sh).
  - wmask = base << sh, where base is 0x01 / 0x03 / 0x0F / 0xFF for B/H/W/D.
  - mem_req_wen = is_store.
- Load extraction:
  - d = rdata >> (8*sh).
  - Truncate d to the size, then sign-extend from bit 7/15/31, or zero-extend if unsigned.
  - D ignores in_unsigned.
- Latency: in-handshake to out_valid is 3 cycles minimum, assuming mem_req_ready is high in REQ and the response arrives the cycle after acceptance. A misaligned access takes 1 cycle.
- Throughput: at most one access per 4 cycles.

Decomposition:
- Shared package (include/defines):
  - size encodings (SIZE_B/H/W/D)
  - FSM state constants
  - XLEN
- Sub-module lsu_align, purely combinational, takes addr[2:0], size and unsigned:
  - produces the store wdata/wmask
  - produces the extended load data
  - produces the misalign flag

Test Plan:
- Aligned load: LD at 0x80000010, rdata=0x1122334455667788, ready/resp immediate -> mem_req_addr=0x80000010, out_rdata=0x1122334455667788, out_valid 3 cycles after accept.
- Sign-extended byte load: LB at 0x80000003, rdata=0x00000000F0000000 -> out_rdata=0xFFFFFFFFFFFFFFF0. Same access with LBU -> 0x00000000000000F0.
- Half store: SH at 0x80000006, wdata=0xABCD -> mem_req_addr=0x80000000, wmask=0xC0, wdata=0xABCD000000000000, wen=1, out_rdata=0.
- Misaligned: LW at 0x80000002 -> no mem_req_valid, out_misalign=1 after 1 cycle, out_rdata=0.
- Backpressure: mem_req_ready low for 5 cycles and out_ready low for 3 cycles -> request fields and outputs stay stable, in_ready=0 throughout.
- Reset in WAIT, then a late mem_resp_valid -> FSM stays in IDLE, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store stage: access sizes, FSM states and
// the byte-strobe pattern for each size.
package mem_lsu_pkg;
    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  size_mask = 8'h01;
            SIZE_H:  size_mask = 8'h03;
            SIZE_W:  size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction
endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for one aligned 64-bit doubleword: store data/strobes,
// load extraction with sign/zero extension, and the misalignment check.
module lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int DW = XLEN
) (
    input  logic [2:0]    addr_lo,
    input  logic [1:0]    size,
    input  logic          is_unsigned,
    input  logic [DW-1:0] store_data,
    input  logic [DW-1:0] load_data,
    output logic [DW-1:0] wdata,
    output logic [7:0]    wmask,
    output logic [DW-1:0] rdata_ext,
    output logic          misalign
);
    logic [5:0]    bit_sh;
    logic [DW-1:0] shifted;

    assign bit_sh  = {addr_lo, 3'b000};
    assign wdata   = store_data << bit_sh;
    assign wmask   = size_mask(size) << addr_lo;
    assign shifted = load_data >> bit_sh;

    always_comb begin
        rdata_ext = shifted;
        misalign  = 1'b0;
        case (size)
            SIZE_B: begin
                rdata_ext = is_unsigned ? {{(DW-8){1'b0}}, shifted[7:0]}
                                        : {{(DW-8){shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                misalign  = addr_lo[0];
                rdata_ext = is_unsigned ? {{(DW-16){1'b0}}, shifted[15:0]}
                                        : {{(DW-16){shifted[15]}}, shifted[15:0]};
            end
            SIZE_W: begin
                misalign  = |addr_lo[1:0];
                rdata_ext = is_unsigned ? {{(DW-32){1'b0}}, shifted[31:0]}
                                        : {{(DW-32){shifted[31]}}, shifted[31:0]};
            end
            default: begin
                misalign  = |addr_lo;
                rdata_ext = shifted;
            end
        endcase
    end
endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: one aligned request per access, loads extended on
// return, misaligned accesses trapped without touching memory.
module mem_lsu #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic            in_is_store,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [RD_W-1:0] in_rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic            mem_req_wen,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [7:0]      mem_req_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic [RD_W-1:0] out_rd,
    output logic            out_is_store,
    output logic            out_misalign
);
    import mem_lsu_pkg::*;

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
    logic            is_store_q, uns_q, misalign_q;
    logic [1:0]      size_q;
    logic [RD_W-1:0] rd_q;

    logic [2:0]      al_addr;
    logic [1:0]      al_size;
    logic [XLEN-1:0] al_wdata, al_rdata;
    logic [7:0]      al_wmask;
    logic            al_misalign;

    // In IDLE the aligner checks the incoming access; afterwards it works on the latched one.
    assign al_addr = (state_q == ST_IDLE) ? in_addr[2:0] : addr_q[2:0];
    assign al_size = (state_q == ST_IDLE) ? in_size      : size_q;

    lsu_align #(.DW(XLEN)) u_align (
        .addr_lo     (al_addr),
        .size        (al_size),
        .is_unsigned (uns_q),
        .store_data  (wdata_q),
        .load_data   (mem_resp_rdata),
        .wdata       (al_wdata),
        .wmask       (al_wmask),
        .rdata_ext   (al_rdata),
        .misalign    (al_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)       state_d = al_misalign ? ST_DONE : ST_REQ;
            ST_REQ:  if (mem_req_ready)  state_d = ST_WAIT;
            ST_WAIT: if (mem_resp_valid) state_d = ST_DONE;
            ST_DONE: if (out_ready)      state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (state_q == ST_IDLE);
        mem_req_valid = (state_q == ST_REQ);
        out_valid     = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            is_store_q <= 1'b0;
            uns_q      <= 1'b0;
            misalign_q <= 1'b0;
            size_q     <= 2'd0;
            rd_q       <= '0;
        end else begin
            if (state_q == ST_IDLE && in_valid) begin
                addr_q     <= in_addr;
                wdata_q    <= in_wdata;
                is_store_q <= in_is_store;
                uns_q      <= in_unsigned;
                size_q     <= in_size;
                rd_q       <= in_rd;
                misalign_q <= al_misalign;
                rdata_q    <= '0;
            end
            if (state_q == ST_WAIT && mem_resp_valid)
                rdata_q <= is_store_q ? '0 : al_rdata;
        end
    end

    assign mem_req_addr  = mem_req_valid ? {addr_q[XLEN-1:3], 3'b000} : '0;
    assign mem_req_wen   = mem_req_valid & is_store_q;
    assign mem_req_wdata = mem_req_valid ? al_wdata : '0;
    assign mem_req_wmask = mem_req_valid ? al_wmask : 8'h00;

    assign out_rdata    = out_valid ? rdata_q : '0;
    assign out_rd       = out_valid ? rd_q : '0;
    assign out_is_store = out_valid & is_store_q;
    assign out_misalign = out_valid & misalign_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, hand sequences for reset corner
// cases, and random accesses checked against a byte-level reference model.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [63:0] in_addr, in_wdata;
    logic        in_is_store;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [4:0]  in_rd;
    logic        mem_req_valid, mem_req_ready;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic        mem_req_wen;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        out_valid, out_ready;
    logic [63:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_is_store, out_misalign;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_lsu #(.XLEN(64), .RD_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_is_store(in_is_store), .in_size(in_size), .in_unsigned(in_unsigned), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
        .out_is_store(out_is_store), .out_misalign(out_misalign)
    );

    typedef struct {
        bit          st;
        logic [1:0]  size;
        bit          uns;
        logic [63:0] addr, wdata, rdata;
        int          rdly, odly;
        logic [4:0]  rd;
    } acc_t;

    typedef struct {
        bit          mis;
        logic [63:0] addr, wdata;
        logic [7:0]  mask;
        logic [63:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        acc_t a;
        exp_t e;
    } vec_t;

    typedef struct {
        bit          saw_req, timeout, back_idle;
        logic [63:0] addr, wdata, rdata;
        logic [7:0]  mask;
        logic        wen, mis, is_store;
        logic [4:0]  rd;
        int          lat, unstable;
    } obs_t;

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic acc_t mk_acc(bit st, logic [1:0] size, bit uns, logic [63:0] addr,
                                    logic [63:0] wdata, logic [63:0] rdata, int rdly, int odly);
        acc_t a;
        a.st = st; a.size = size; a.uns = uns; a.addr = addr; a.wdata = wdata;
        a.rdata = rdata; a.rdly = rdly; a.odly = odly; a.rd = 5'($urandom);
        return a;
    endfunction

    function automatic exp_t mk_exp(bit mis, logic [63:0] addr, logic [63:0] wdata,
                                    logic [7:0] mask, logic [63:0] rdata, int lat);
        exp_t e;
        e.mis = mis; e.addr = addr; e.wdata = wdata; e.mask = mask; e.rdata = rdata; e.lat = lat;
        return e;
    endfunction

    // Reference: the access touches 2**size bytes starting at byte lane addr%8.
    function automatic exp_t model(acc_t a);
        exp_t        e;
        int          n, sh;
        logic [63:0] v;
        n  = 1 << a.size;
        sh = int'(a.addr[2:0]);
        e  = mk_exp(0, {a.addr[63:3], 3'b000}, 64'h0, 8'h00, 64'h0, 0);
        e.mis = (sh % n) != 0;
        e.lat = e.mis ? 1 : 3 + a.rdly;
        if (!e.mis) begin
            if (a.st) begin
                for (int j = sh; j < 8; j++) e.wdata[8*j +: 8] = a.wdata[8*(j-sh) +: 8];
                for (int j = 0; j < n; j++) e.mask[sh+j] = 1'b1;
            end else begin
                v = '0;
                for (int j = 0; j < n; j++) v[8*j +: 8] = a.rdata[8*(sh+j) +: 8];
                if (n < 8 && !a.uns && v[8*n-1])
                    for (int j = n; j < 8; j++) v[8*j +: 8] = 8'hFF;
                e.rdata = v;
            end
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_acc(input acc_t a, output obs_t o);
        int cyc, rq_wait;
        bit acc_last;
        o = '{default: 0};
        @(negedge clk);
        in_valid = 1; in_addr = a.addr; in_wdata = a.wdata; in_is_store = a.st;
        in_size = a.size; in_unsigned = a.uns; in_rd = a.rd;
        @(negedge clk);
        in_valid = 0; in_addr = rand64(); in_wdata = rand64(); in_rd = 5'($urandom);
        in_size = 2'($urandom); in_unsigned = 1'($urandom); in_is_store = 1'($urandom);
        cyc = 1; rq_wait = 0; acc_last = 0;
        while (!out_valid && cyc < 40) begin
            if (in_ready) o.unstable++;
            mem_resp_valid = acc_last;
            mem_resp_rdata = acc_last ? a.rdata : rand64();
            acc_last = 0;
            if (mem_req_valid) begin
                if (!o.saw_req) begin
                    o.saw_req = 1; o.addr = mem_req_addr; o.wdata = mem_req_wdata;
                    o.mask = mem_req_wmask; o.wen = mem_req_wen;
                end else if (o.addr !== mem_req_addr || o.wdata !== mem_req_wdata ||
                             o.mask !== mem_req_wmask || o.wen !== mem_req_wen) begin
                    o.unstable++;
                end
                mem_req_ready = (rq_wait >= a.rdly);
                acc_last = mem_req_ready;
                rq_wait++;
                if (!mem_req_ready) mem_resp_valid = 1'($urandom);
            end else begin
                mem_req_ready = 0;
            end
            @(negedge clk);
            cyc++;
        end
        mem_resp_valid = 0; mem_req_ready = 0;
        o.lat = cyc;
        o.timeout = !out_valid;
        o.rdata = out_rdata; o.mis = out_misalign; o.rd = out_rd; o.is_store = out_is_store;
        for (int k = 0; k < a.odly; k++) begin
            out_ready = 0;
            mem_resp_valid = 1'($urandom); mem_resp_rdata = rand64();
            @(negedge clk);
            if (!out_valid || out_rdata !== o.rdata || out_misalign !== o.mis ||
                out_rd !== o.rd || in_ready || mem_req_valid)
                o.unstable++;
        end
        mem_resp_valid = 0;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        o.back_idle = in_ready && !out_valid;
    endtask

    task automatic check_acc(input string tag, input acc_t a, input exp_t e);
        obs_t o;
        run_acc(a, o);
        chk({tag, "_timeout"}, 64'(o.timeout), 64'd0);
        chk({tag, "_req_issued"}, 64'(o.saw_req), 64'(!e.mis));
        chk({tag, "_misalign"}, 64'(o.mis), 64'(e.mis));
        chk({tag, "_rdata"}, o.rdata, e.rdata);
        chk({tag, "_rd"}, 64'(o.rd), 64'(a.rd));
        chk({tag, "_is_store"}, 64'(o.is_store), 64'(a.st));
        chk({tag, "_latency"}, 64'(o.lat), 64'(e.lat));
        chk({tag, "_stable"}, 64'(o.unstable), 64'd0);
        chk({tag, "_back_idle"}, 64'(o.back_idle), 64'd1);
        if (!e.mis) begin
            chk({tag, "_req_addr"}, o.addr, e.addr);
            chk({tag, "_wen"}, 64'(o.wen), 64'(a.st));
            if (a.st) begin
                chk({tag, "_wdata"}, o.wdata, e.wdata);
                chk({tag, "_wmask"}, 64'(o.mask), 64'(e.mask));
            end
        end
    endtask

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_t a;
        vecs[0] = '{mk_acc(0, 2'd3, 0, 64'h80000010, 64'h0, 64'h1122334455667788, 0, 0),
                    mk_exp(0, 64'h80000010, 64'h0, 8'h00, 64'h1122334455667788, 3)};
        vecs[1] = '{mk_acc(0, 2'd0, 0, 64'h80000003, 64'h0, 64'h00000000F0000000, 0, 0),
                    mk_exp(0, 64'h80000000, 64'h0, 8'h00, 64'hFFFFFFFFFFFFFFF0, 3)};
        vecs[2] = '{mk_acc(0, 2'd0, 1, 64'h80000003, 64'h0, 64'h00000000F0000000, 0, 0),
                    mk_exp(0, 64'h80000000, 64'h0, 8'h00, 64'h00000000000000F0, 3)};
        vecs[3] = '{mk_acc(1, 2'd1, 0, 64'h80000006, 64'hABCD, 64'h0, 0, 0),
                    mk_exp(0, 64'h80000000, 64'hABCD000000000000, 8'hC0, 64'h0, 3)};
        vecs[4] = '{mk_acc(0, 2'd2, 0, 64'h80000002, 64'h0, 64'h0, 0, 0),
                    mk_exp(1, 64'h0, 64'h0, 8'h00, 64'h0, 1)};
        vecs[5] = '{mk_acc(0, 2'd2, 0, 64'h80000004, 64'h0, 64'h8765432100000000, 5, 3),
                    mk_exp(0, 64'h80000000, 64'h0, 8'h00, 64'hFFFFFFFF87654321, 8)};
        vecs[6] = '{mk_acc(0, 2'd1, 1, 64'h8000000A, 64'h0, 64'h00000000BEEF0000, 0, 1),
                    mk_exp(0, 64'h80000008, 64'h0, 8'h00, 64'h000000000000BEEF, 3)};
        vecs[7] = '{mk_acc(0, 2'd1, 0, 64'h8000000A, 64'h0, 64'h00000000BEEF0000, 1, 0),
                    mk_exp(0, 64'h80000008, 64'h0, 8'h00, 64'hFFFFFFFFFFFFBEEF, 4)};
        vecs[8] = '{mk_acc(1, 2'd3, 0, 64'h80000004, 64'h1234, 64'h0, 0, 2),
                    mk_exp(1, 64'h0, 64'h0, 8'h00, 64'h0, 1)};
        vecs[9] = '{mk_acc(1, 2'd0, 0, 64'h80000005, 64'h5A, 64'h0, 2, 0),
                    mk_exp(0, 64'h80000000, 64'h00005A0000000000, 8'h20, 64'h0, 5)};

        rst = 1; in_valid = 0; in_addr = '0; in_wdata = '0; in_is_store = 0; in_size = '0;
        in_unsigned = 0; in_rd = '0; mem_req_ready = 0; mem_resp_valid = 0;
        mem_resp_rdata = '0; out_ready = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_req_valid", 64'(mem_req_valid), 64'd0);
        chk("reset_out_rdata", out_rdata, 64'd0);
        chk("reset_out_misalign", 64'(out_misalign), 64'd0);
        chk("reset_req_addr", mem_req_addr, 64'd0);

        for (int i = 0; i < 10; i++)
            check_acc($sformatf("vec%0d", i), vecs[i].a, vecs[i].e);

        // reset while waiting for the response, then a late response
        a = vecs[0].a;
        @(negedge clk);
        in_valid = 1; in_addr = a.addr; in_size = a.size; in_is_store = 0; in_unsigned = 0;
        @(negedge clk);
        in_valid = 0;
        chk("rstwait_in_req", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        chk("rstwait_req_dropped", 64'(mem_req_valid), 64'd0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        mem_resp_valid = 1; mem_resp_rdata = 64'hDEADBEEFDEADBEEF;
        chk("rstwait_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        mem_resp_valid = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rstwait_out_valid_%0d", k), 64'(out_valid), 64'd0);
            chk($sformatf("rstwait_idle_%0d", k), 64'(in_ready), 64'd1);
            chk($sformatf("rstwait_no_req_%0d", k), 64'(mem_req_valid), 64'd0);
            @(negedge clk);
        end

        // reset while the request is stalled
        in_valid = 1; in_addr = 64'h80000020; in_size = 2'd3;
        @(negedge clk);
        in_valid = 0;
        chk("rstreq_req_valid", 64'(mem_req_valid), 64'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstreq_req_dropped", 64'(mem_req_valid), 64'd0);
        chk("rstreq_req_addr", mem_req_addr, 64'd0);
        chk("rstreq_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 80; i++) begin
            a = mk_acc(1'($urandom), 2'($urandom), 1'($urandom),
                       {32'h80000000, 29'($urandom), 3'($urandom)},
                       rand64(), rand64(), $urandom_range(0, 2), $urandom_range(0, 2));
            check_acc($sformatf("rnd%0d", i), a, model(a));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
